alu_sequencer: RTL and testbench

//   Program sequencer for the 4-bit ALU datapath (add/sub/and/or/xor/sll/srl/sra/pass).
//   A short program of {func, operand} slots is loaded over a valid/ready port and run on start.

---
 rtl/alu_sequencer_if.sv | 43 ++++
 rtl/alu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
//   Bundle of every non-clock/reset signal of the ALU sequencer.
//   master : host + combinational ALU side (drives program load, control,
//            accumulator seed and the ALU result/flags).
//   slave  : the sequencer itself.
//   Signals:
//     ld_valid/ld_ready/ld_data  program word load handshake ([7:4]=func, [3:0]=B)
//     clear, start, init_acc, stop_on_v   run control
//     busy, done, acc, flags              run status / accumulator
//     alu_a, alu_b, alu_func              operands to the ALU
//     alu_y, alu_flags                    ALU result and {Z,N,C,V}
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_data;
    logic       clear;
    logic       start;
    logic [3:0] init_acc;
    logic       stop_on_v;
    logic       busy;
    logic       done;
    logic [3:0] acc;
    logic [3:0] flags;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_func;
    logic [3:0] alu_y;
    logic [3:0] alu_flags;

    modport master (
        output ld_valid, ld_data, clear, start, init_acc, stop_on_v,
               alu_y, alu_flags,
        input  ld_ready, busy, done, acc, flags, alu_a, alu_b, alu_func
    );

    modport slave (
        input  ld_valid, ld_data, clear, start, init_acc, stop_on_v,
               alu_y, alu_flags,
        output ld_ready, busy, done, acc, flags, alu_a, alu_b, alu_func
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Runs a short program of {func, operand} slots against an external
//   combinational 4-bit ALU: each slot does acc <= ALU(acc, operand, func).
//   Program words are loaded over a valid/ready port while idle and kept
//   across runs; start seeds the accumulator and steps through the slots,
//   two cycles per slot (ISSUE drives the ALU, CAPTURE latches its result).
//   func 4'b0111 is HALT and ends the run without touching acc/flags.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high; clears state and empties the program
//     bus    alu_sequencer_if.slave (load port, control, status, ALU bus)
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [3:0]        HALT    = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [3:0]        acc_reg;
    logic [3:0]        flags_reg;
    logic [3:0]        alu_a_reg;
    logic [3:0]        alu_b_reg;
    logic [3:0]        alu_func_reg;

    // Program store; written only while idle, read through the ALU operand
    // registers so the array maps onto block RAM with a registered read.
    logic [7:0]        slot_mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_word;

    logic              ld_ready;
    logic              load_fire;
    logic [ADDR_W-1:0] pc_inc;
    logic              last_slot;
    logic              cap_end;

    assign pc_inc    = pc_reg + PC_ONE;
    assign last_slot = ({1'b0, pc_reg} == (count_reg - CNT_ONE));
    assign cap_end   = last_slot || (bus.stop_on_v && bus.alu_flags[0]);

    // Start and clear both take priority over a load in the same cycle,
    // so ready is withheld while either is requested.
    assign ld_ready  = (state_reg == ST_IDLE) && (count_reg < DEPTH_C)
                       && !bus.start && !bus.clear;
    assign load_fire = bus.ld_valid && ld_ready;

    // Slot 0 is fetched on start; the following slot is fetched in CAPTURE.
    assign rd_addr = (state_reg == ST_CAPTURE) ? pc_inc : '0;
    assign rd_word = slot_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (load_fire) begin
            slot_mem[count_reg[ADDR_W-1:0]] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = (count_reg != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                state_next = (alu_func_reg == HALT) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_next = cap_end ? ST_DONE : ST_ISSUE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            pc_reg       <= '0;
            acc_reg      <= '0;
            flags_reg    <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_func_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_reg   <= bus.init_acc;
                        flags_reg <= '0;
                        pc_reg    <= '0;
                        if (count_reg != '0) begin
                            alu_a_reg    <= bus.init_acc;
                            alu_b_reg    <= rd_word[3:0];
                            alu_func_reg <= rd_word[7:4];
                        end
                    end else if (bus.clear) begin
                        count_reg <= '0;
                    end else if (load_fire) begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                ST_ISSUE: begin
                    if (alu_func_reg == HALT) begin
                        alu_a_reg    <= '0;
                        alu_b_reg    <= '0;
                        alu_func_reg <= '0;
                    end
                end
                ST_CAPTURE: begin
                    acc_reg   <= bus.alu_y;
                    flags_reg <= bus.alu_flags;
                    if (cap_end) begin
                        alu_a_reg    <= '0;
                        alu_b_reg    <= '0;
                        alu_func_reg <= '0;
                    end else begin
                        // The next ISSUE sees the freshly captured result as A.
                        pc_reg       <= pc_inc;
                        alu_a_reg    <= bus.alu_y;
                        alu_b_reg    <= rd_word[3:0];
                        alu_func_reg <= rd_word[7:4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ld_ready = ld_ready;
    assign bus.busy     = (state_reg == ST_ISSUE) || (state_reg == ST_CAPTURE);
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.acc      = acc_reg;
    assign bus.flags    = flags_reg;
    assign bus.alu_a    = alu_a_reg;
    assign bus.alu_b    = alu_b_reg;
    assign bus.alu_func = alu_func_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Drives program loads and runs into alu_sequencer, plays the role of the
//   combinational ALU, and checks every done pulse against a reference model
//   queued when the run is started.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural 4-bit ALU: returns {y, Z, N, C, V}.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] f);
        logic [4:0] s;
        logic [3:0] y;
        logic       c;
        logic       v;
        s = '0; c = 1'b0; v = 1'b0;
        case (f)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b}; y = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (y[3] != a[3]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b}; y = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (y[3] != a[3]);
            end
            4'd4:    y = a & b;
            4'd5:    y = a | b;
            4'd6:    y = a ^ b;
            4'd8:    begin y = {a[2:0], 1'b0}; c = a[3]; end
            4'd9:    begin y = {1'b0, a[3:1]}; c = a[0]; end
            4'd10:   begin y = {a[3], a[3:1]}; c = a[0]; end
            4'd15:   y = b;
            default: y = a ^ ~b;
        endcase
        return {y, (y == 4'd0), y[3], c, v};
    endfunction

    assign {bus.alu_y, bus.alu_flags} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_func);

    typedef struct {
        logic [3:0] acc;
        logic [3:0] flags;
        int         lat;
        int         busy;
        int         c0;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] prog[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes one expectation per done pulse.
    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (!bus.busy) chk("alu_idle_zero", {bus.alu_a, bus.alu_b, bus.alu_func}, 12'h0);
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done at t=%0t", $time);
                    end else begin
                        e = sb.pop_front();
                        $display("run done: acc=%0h flags=%b lat=%0d busy=%0d", bus.acc, bus.flags,
                                 cyc - e.c0, busy_cnt);
                        chk("done_acc", bus.acc, e.acc);
                        chk("done_flags", bus.flags, e.flags);
                        chk("done_latency", cyc - e.c0, e.lat);
                        chk("busy_cycles", busy_cnt, e.busy);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic drive_idle();
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.clear    = 1'b0;
        bus.start    = 1'b0;
    endtask

    // Presents one word (optionally with clear) for one cycle; ld_valid stays
    // asserted afterwards so back-to-back calls hold it continuously.
    task automatic load(input logic [7:0] d, input logic with_clear);
        logic exp_ready;
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.clear    = with_clear;
        bus.start    = 1'b0;
        exp_ready = !with_clear && (prog.size() < 8);
        #1;
        chk("ld_ready", bus.ld_ready, exp_ready);
        @(posedge clk);
        if (with_clear) prog.delete();
        else if (exp_ready) prog.push_back(d);
        $display("load: data=%02h clear=%0d accepted=%0d count=%0d", d, with_clear, exp_ready,
                 prog.size());
    endtask

    task automatic run(input logic [3:0] init, input logic sov, input logic with_clear,
                       input logic fixed, input logic [3:0] facc, input logic [3:0] fflags,
                       input int flat);
        logic [3:0] m_acc;
        logic [3:0] m_flg;
        logic [7:0] w;
        logic [7:0] r;
        int         ex;
        int         halted;
        exp_t       e;
        int         k;
        m_acc = init; m_flg = 4'd0; ex = 0; halted = 0;
        foreach (prog[i]) begin
            w = prog[i];
            if (w[7:4] == 4'd7) begin
                halted = 1;
                break;
            end
            r = alu_ref(m_acc, w[3:0], w[7:4]);
            m_acc = r[7:4];
            m_flg = r[3:0];
            ex++;
            if (sov && m_flg[0]) break;
        end
        e.acc   = fixed ? facc : m_acc;
        e.flags = fixed ? fflags : m_flg;
        e.lat   = fixed ? flat : (2 * ex + halted + 1);
        e.busy  = 2 * ex + halted;
        @(negedge clk);
        bus.ld_valid  = 1'($urandom_range(0, 1));
        bus.ld_data   = 8'($urandom);
        bus.clear     = with_clear;
        bus.start     = 1'b1;
        bus.init_acc  = init;
        bus.stop_on_v = sov;
        #1;
        chk("ld_ready_on_start", bus.ld_ready, 1'b0);
        e.c0 = cyc;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.clear    = 1'b0;
        bus.ld_valid = 1'b0;
        sb.push_back(e);
        $display("start: init=%0h sov=%0d count=%0d exp_acc=%0h exp_flags=%b", init, sov,
                 prog.size(), e.acc, e.flags);
        // Throw ignored inputs at the block while it runs.
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
            chk("ld_ready_running", bus.ld_ready, 1'b0);
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_data  = 8'($urandom);
            bus.start    = 1'($urandom_range(0, 1));
            bus.clear    = 1'($urandom_range(0, 1));
            bus.init_acc = 4'($urandom);
        end
        bus.ld_valid = 1'b0;
        bus.start    = 1'b0;
        bus.clear    = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout after %0d cycles", k);
            sb.delete();
        end
    endtask

    function automatic logic [7:0] rand_word(input logic allow_halt);
        logic [3:0] f;
        f = 4'($urandom_range(0, 15));
        if (f == 4'd7 && (!allow_halt || $urandom_range(0, 2) != 0)) f = 4'd0;
        return {f, 4'($urandom)};
    endfunction

    initial begin : driver
        int n;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'h00;
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.init_acc  = 4'h0;
        bus.stop_on_v = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_acc", bus.acc, 4'h0);
        chk("rst_flags", bus.flags, 4'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_func}, 12'h0);
        reset = 1'b0;
        #1;
        chk("rst_ld_ready", bus.ld_ready, 1'b1);

        // Basic three-slot program.
        load(8'h03, 1'b0); load(8'h11, 1'b0); load(8'h80, 1'b0);
        drive_idle();
        run(4'd2, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0100, 7);
        // Rerun without reloading.
        run(4'd2, 1'b0, 1'b0, 1'b1, 4'd8, 4'b0100, 7);

        // Stop on overflow.
        load(8'h00, 1'b1); load(8'h01, 1'b0); load(8'h01, 1'b0);
        drive_idle();
        run(4'd7, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0101, 3);

        // Overfill: nine words with ld_valid held.
        load(8'h00, 1'b1);
        for (int i = 0; i < 9; i++) load(rand_word(1'b0), 1'b0);
        drive_idle();
        #1;
        chk("ld_ready_full", bus.ld_ready, 1'b0);
        run(4'($urandom), 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 0);

        // HALT in the middle.
        load(8'h00, 1'b1); load(8'h01, 1'b0); load(8'h7F, 1'b0); load(8'h01, 1'b0);
        drive_idle();
        run(4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 4'b0000, 4);

        // Empty program.
        load(8'h00, 1'b1);
        drive_idle();
        run(4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 4'b0000, 1);

        // Start and clear together: start wins, program survives.
        load(8'h03, 1'b0); load(8'hF9, 1'b0);
        drive_idle();
        run(4'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 0);
        run(4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 0);

        // Reset during CAPTURE.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.init_acc = 4'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_acc", bus.acc, 4'h0);
        chk("midrst_flags", bus.flags, 4'h0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        prog.delete();
        #1;
        chk("midrst_ld_ready", bus.ld_ready, 1'b1);
        $display("reset mid-run applied and released");
        run(4'd9, 1'b0, 1'b0, 1'b1, 4'd9, 4'b0000, 1);

        // Randomised programs and runs.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) load(8'($urandom), 1'b1);
            n = $urandom_range(0, 9);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 2) == 0) drive_idle();
                load(rand_word(1'b1), 1'b0);
            end
            drive_idle();
            run(4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'b0, 4'd0, 4'd0, 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
